// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce / edge-detect block.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } state_t;

  localparam int SYNC_STAGES_DEF   = 2;
  localparam int STABLE_CYCLES_DEF = 4;
  localparam int CNT_W_DEF         = 8;

  function automatic logic is_chk(input state_t st);
    return (st == CHK_HI) || (st == CHK_LO);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Shift register of posedge flops with synchronous reset; output is the last stage.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/debounce_edge_detect.sv
// Synchronises d, qualifies each new level for STABLE_CYCLES enabled cycles,
// and emits a registered level plus one-cycle rise/fall pulses.
//
// state   | meaning
// IDLE_LO | out=0, synchronised input agrees
// CHK_HI  | s=1 seen, counting agreement before raising out
// IDLE_HI | out=1, synchronised input agrees
// CHK_LO  | s=0 seen, counting agreement before dropping out
module debounce_edge_detect
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  input  logic en,
  output logic out,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             out_nxt, rise_nxt, fall_nxt, busy_nxt;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE_LO;
      cnt   <= '0;
      out   <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      out   <= out_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
      busy  <= busy_nxt;
    end
  end

  // en=0 freezes both state and counter, so glitches while disabled are invisible.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (en) begin
      case (state)
        IDLE_LO: begin
          if (s) begin
            state_nxt = CHK_HI;
            cnt_nxt   = CNT_ONE;
          end
        end
        CHK_HI: begin
          if (!s) begin
            state_nxt = IDLE_LO;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = IDLE_HI;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        IDLE_HI: begin
          if (!s) begin
            state_nxt = CHK_LO;
            cnt_nxt   = CNT_ONE;
          end
        end
        CHK_LO: begin
          if (s) begin
            state_nxt = IDLE_HI;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = IDLE_LO;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = IDLE_LO;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    rise_nxt = (state == CHK_HI) && (state_nxt == IDLE_HI);
    fall_nxt = (state == CHK_LO) && (state_nxt == IDLE_LO);
    out_nxt  = out;
    if (rise_nxt) out_nxt = 1'b1;
    if (fall_nxt) out_nxt = 1'b0;
    busy_nxt = is_chk(state_nxt);
  end

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Self-checking bench: directed latency scenarios plus randomized traffic
// compared cycle by cycle against a run-length reference model.
module tb_debounce_edge_detect;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic rst, d, en;
  logic out, rise, fall, busy;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic m_sh [SYNC];
  logic m_out, m_rise, m_fall, m_busy;
  int   m_run;

  always #10 clk = ~clk;

  debounce_edge_detect #(
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE),
    .CNT_W         (8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .d    (d),
    .en   (en),
    .out  (out),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // out follows the synchronised input once it has differed from out for
  // STABLE consecutive enabled cycles; any agreeing cycle resets the run.
  task automatic model_edge(input logic d_i, input logic en_i, input logic rst_i);
    logic s;
    if (rst_i) begin
      for (int i = 0; i < SYNC; i++) m_sh[i] = 1'b0;
      m_out = 0; m_rise = 0; m_fall = 0; m_run = 0;
    end else begin
      s = m_sh[SYNC-1];
      for (int i = SYNC-1; i > 0; i--) m_sh[i] = m_sh[i-1];
      m_sh[0] = d_i;
      m_rise = 0;
      m_fall = 0;
      if (en_i) begin
        if (s != m_out) begin
          m_run++;
          if (m_run == STABLE) begin
            m_out  = s;
            m_rise = s;
            m_fall = !s;
            m_run  = 0;
          end
        end else begin
          m_run = 0;
        end
      end
    end
    m_busy = (m_run != 0);
  endtask

  task automatic step(input logic d_i, input logic en_i, input logic rst_i);
    @(negedge clk);
    d = d_i; en = en_i; rst = rst_i;
    @(posedge clk);
    model_edge(d_i, en_i, rst_i);
    #1;
    check("out",  out,  m_out);
    check("rise", rise, m_rise);
    check("fall", fall, m_fall);
    check("busy", busy, m_busy);
  endtask

  // Drive a level for n edges; report first rise/fall edge, pulse counts, busy edges.
  task automatic hold(input logic d_i, input int n, output int rise_at, output int fall_at,
                      output int nrise, output int nfall, output int busy_mask);
    rise_at = 0; fall_at = 0; nrise = 0; nfall = 0; busy_mask = 0;
    for (int i = 1; i <= n; i++) begin
      step(d_i, 1'b1, 1'b0);
      if (rise) begin nrise++; if (rise_at == 0) rise_at = i; end
      if (fall) begin nfall++; if (fall_at == 0) fall_at = i; end
      if (busy) busy_mask |= (1 << i);
    end
  endtask

  int ra, fa, nr, nf, bm, edge_no;

  initial begin
    rst = 1'b1; d = 1'b1; en = 1'b1;
    for (int i = 0; i < SYNC; i++) m_sh[i] = 1'b0;
    m_out = 0; m_rise = 0; m_fall = 0; m_busy = 0; m_run = 0;

    // 1: reset held with d=1, rise after release on edge 6
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    check("t1_reset_out", out, 0);
    hold(1'b1, 10, ra, fa, nr, nf, bm);
    check("t1_rise_edge", ra, SYNC + STABLE);
    check("t1_rise_cnt", nr, 1);

    // 5: from out=1, d->0 held
    hold(1'b0, 10, ra, fa, nr, nf, bm);
    check("t5_fall_edge", fa, SYNC + STABLE);
    check("t5_fall_cnt", nf, 1);
    check("t5_rise_cnt", nr, 0);
    check("t5_out", out, 0);

    // 2: d 0->1 held 10; busy on edges 3-5
    hold(1'b1, 10, ra, fa, nr, nf, bm);
    check("t2_rise_edge", ra, SYNC + STABLE);
    check("t2_rise_cnt", nr, 1);
    check("t2_fall_cnt", nf, 0);
    check("t2_busy_mask", bm, 32'h38);
    hold(1'b0, 10, ra, fa, nr, nf, bm);

    // 3: d=1 for 3 cycles then 0
    hold(1'b1, 3, ra, fa, nr, nf, bm);
    hold(1'b0, 8, ra, fa, nr, nf, bm);
    check("t3_rise_cnt", nr, 0);
    check("t3_out", out, 0);
    check("t3_busy", busy, 0);

    // 4: toggle every cycle
    nr = 0; nf = 0;
    for (int i = 0; i < 20; i++) begin
      step(i[0], 1'b1, 1'b0);
      if (rise) nr++;
      if (fall) nf++;
    end
    check("t4_pulses", nr + nf, 0);
    hold(1'b0, 8, ra, fa, nr, nf, bm);

    // 6a: en low 3 cycles during CHK_HI delays rise by 3
    edge_no = 0; ra = 0;
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, !(i >= 4 && i <= 6), 1'b0);
      if (rise && ra == 0) ra = i;
    end
    check("t6a_rise_edge", ra, SYNC + STABLE + 3);
    hold(1'b0, 10, ra, fa, nr, nf, bm);

    // 6b: reset mid-CHK_HI
    hold(1'b1, 4, ra, fa, nr, nf, bm);
    check("t6b_busy_pre", busy, 1);
    step(1'b1, 1'b1, 1'b1);
    check("t6b_busy", busy, 0);
    check("t6b_rise", rise, 0);
    check("t6b_out", out, 0);

    // glitch while disabled is ignored
    hold(1'b0, 6, ra, fa, nr, nf, bm);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
    hold(1'b0, 6, ra, fa, nr, nf, bm);
    check("glitch_en0", nr, 0);

    // randomized traffic: sticky d, mostly enabled, rare resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 25) d = ~d;
      step(d, ($urandom_range(0, 99) < 85), ($urandom_range(0, 199) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
